// File: rtl/game_field_ctrl.sv
// Playfield controller: one falling cell on a COLS x ROWS grid with gravity,
// collision, locking, full-row clearing, scoring and game-over/restart.
// Cell index = x + COLS*y, y=0 is the top row. One frame is processed per
// accepted draw_finish tick; data_updated is refreshed once per frame.
module game_field_ctrl #(
  parameter int COLS        = 8,
  parameter int ROWS        = 18,
  parameter int GRAV_FRAMES = 30,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           op_keys,
  input  logic                 draw_finish,
  output logic [COLS*ROWS-1:0] data_updated,
  output logic                 game_over,
  output logic [CNT_W-1:0]     lines_cleared,
  output logic                 busy
);

  localparam int N     = COLS * ROWS;
  localparam int X_W   = $clog2(COLS);
  localparam int Y_W   = $clog2(ROWS);
  localparam int G_W   = $clog2(GRAV_FRAMES + 1);
  localparam int IDX_W = $clog2(N);

  // Key bit positions inside op_keys / latches.
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;

  localparam logic [2:0] S_WAIT     = 3'd0;
  localparam logic [2:0] S_HMOVE    = 3'd1;
  localparam logic [2:0] S_VMOVE    = 3'd2;
  localparam logic [2:0] S_LOCK     = 3'd3;
  localparam logic [2:0] S_CLEAR    = 3'd4;
  localparam logic [2:0] S_SPAWN    = 3'd5;
  localparam logic [2:0] S_PUBLISH  = 3'd6;
  localparam logic [2:0] S_OVER_CHK = 3'd7;

  localparam logic [X_W-1:0] X_SPAWN = X_W'(COLS / 2);
  localparam logic [X_W-1:0] X_MAX   = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(ROWS - 1);
  localparam logic [G_W-1:0] G_MAX   = G_W'(GRAV_FRAMES);

  logic [2:0]       state;
  logic [N-1:0]     field;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [Y_W-1:0]   r;
  logic [G_W-1:0]   grav_cnt;
  logic [3:0]       key_latch;
  logic [3:0]       k;

  logic             tick_accept;
  logic [IDX_W-1:0] cur_idx;
  logic             left_free;
  logic             right_free;
  logic             blocked;
  logic             drop_req;
  logic [ROWS-1:0]  row_full;
  logic [N-1:0]     field_shifted;
  logic [N-1:0]     cell_onehot;

  function automatic logic [IDX_W-1:0] idx_of(input logic [X_W-1:0] xx,
                                              input logic [Y_W-1:0] yy);
    return IDX_W'(xx) + IDX_W'(COLS) * IDX_W'(yy);
  endfunction

  assign tick_accept = draw_finish && (state == S_WAIT);
  assign busy        = (state != S_WAIT);

  // Neighbour/collision tests, row fullness and the one-row-down shift for CLEAR.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    cur_idx       = idx_of(x, y);
    left_free     = (x != '0) && !field[idx_of(x - 1'b1, y)];
    right_free    = (x != X_MAX) && !field[idx_of(x + 1'b1, y)];
    blocked       = (y == Y_MAX) || field[idx_of(x, y + 1'b1)];
    drop_req      = k[K_DOWN] || k[K_UP] || (grav_cnt == G_MAX);
    cell_onehot   = N'(1) << cur_idx;
    row_full      = '0;
    field_shifted = field;
    for (int i = 0; i < ROWS; i++) begin
      row_full[i] = &field[i*COLS +: COLS];
      // Rows above the cleared row r slide down one; row 0 becomes empty.
      if (i <= int'(r)) begin
        if (i == 0) field_shifted[i*COLS +: COLS] = '0;
        else        field_shifted[i*COLS +: COLS] = field[(i-1)*COLS +: COLS];
      end
    end
  end

  // Sticky key latches: restart from the current keys on the accept cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)           key_latch <= '0;
    else if (tick_accept) key_latch <= op_keys;
    else                  key_latch <= key_latch | op_keys;
  end

  // Frame sequencer: move, drop, lock, clear rows, respawn and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the field is a plain flop vector (not a RAM), so it is cleared by reset with the rest.
      state         <= S_WAIT;
      field         <= '0;
      x             <= X_SPAWN;
      y             <= '0;
      r             <= '0;
      grav_cnt      <= '0;
      k             <= '0;
      data_updated  <= '0;
      game_over     <= 1'b0;
      lines_cleared <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (draw_finish) begin
            k <= key_latch;
            // Saturate so repeated idle frames in OVER cannot wrap the counter.
            if (grav_cnt != G_MAX) grav_cnt <= grav_cnt + 1'b1;
            state <= game_over ? S_OVER_CHK : S_HMOVE;
          end
        end

        S_HMOVE: begin
          if (k[K_LEFT] && !k[K_RIGHT] && left_free)       x <= x - 1'b1;
          else if (k[K_RIGHT] && !k[K_LEFT] && right_free) x <= x + 1'b1;
          state <= S_VMOVE;
        end

        S_VMOVE: begin
          if (drop_req) begin
            grav_cnt  <= '0;
            k[K_DOWN] <= 1'b0;
            if (blocked) begin
              state <= S_LOCK;
            end else begin
              y     <= y + 1'b1;
              // Hard drop keeps falling one row per cycle until blocked.
              state <= k[K_UP] ? S_VMOVE : S_PUBLISH;
            end
          end else begin
            state <= S_PUBLISH;
          end
        end

        S_LOCK: begin
          field[cur_idx] <= 1'b1;
          r              <= Y_MAX;
          state          <= S_CLEAR;
        end

        S_CLEAR: begin
          if (row_full[r]) begin
            // Re-check the same r: the row shifted into it may also be full.
            field <= field_shifted;
            if (lines_cleared != '1) lines_cleared <= lines_cleared + 1'b1;
          end else if (r == '0) begin
            state <= S_SPAWN;
          end else begin
            r <= r - 1'b1;
          end
        end

        S_SPAWN: begin
          x <= X_SPAWN;
          y <= '0;
          if (field[COLS/2]) game_over <= 1'b1;
          state <= S_PUBLISH;
        end

        S_PUBLISH: begin
          data_updated <= game_over ? field : (field | cell_onehot);
          state        <= S_WAIT;
        end

        S_OVER_CHK: begin
          // Any key press during game over restarts the game.
          if (|k) begin
            field         <= '0;
            lines_cleared <= '0;
            game_over     <= 1'b0;
            grav_cnt      <= '0;
            x             <= X_SPAWN;
            y             <= '0;
          end
          state <= S_PUBLISH;
        end

        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_game_field_ctrl.sv
// Self-checking bench for game_field_ctrl: directed scenarios plus randomized
// frames, compared against a grid-level reference model.
module tb_game_field_ctrl;

  localparam int COLS  = 8;
  localparam int ROWS  = 18;
  localparam int GRAV  = 2;
  localparam int CNT_W = 16;
  localparam int N     = COLS * ROWS;
  localparam int MAXL  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       op_keys = '0;
  logic             draw_finish = 1'b0;
  logic [N-1:0]     data_updated;
  logic             game_over;
  logic [CNT_W-1:0] lines_cleared;
  logic             busy;

  always #5 clk = ~clk;

  game_field_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .GRAV_FRAMES(GRAV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_keys(op_keys), .draw_finish(draw_finish),
    .data_updated(data_updated), .game_over(game_over),
    .lines_cleared(lines_cleared), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int last_cycles;

  // Reference model state: grid[y][x] of settled cells plus the falling cell.
  bit         grid [ROWS][COLS];
  int         mx, my, mgrav, mlines;
  bit         mover;
  logic [3:0] m_latch;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int yy = 0; yy < ROWS; yy++)
      for (int xx = 0; xx < COLS; xx++) grid[yy][xx] = 1'b0;
    mx = COLS / 2; my = 0; mgrav = 0; mlines = 0; mover = 1'b0; m_latch = '0;
  endfunction

  function automatic logic [N-1:0] model_view();
    logic [N-1:0] v = '0;
    for (int yy = 0; yy < ROWS; yy++)
      for (int xx = 0; xx < COLS; xx++)
        if (grid[yy][xx]) v[xx + COLS*yy] = 1'b1;
    if (!mover) v[mx + COLS*my] = 1'b1;
    return v;
  endfunction

  // One whole frame computed from the game rules for key snapshot k.
  function automatic void model_frame(input logic [3:0] k);
    bit up = k[0], down = k[1], left = k[2], right = k[3];
    bit locked = 1'b0;
    bit ng [ROWS][COLS];
    int dst, cleared;
    bit full;
    if (mgrav < GRAV) mgrav++;
    if (mover) begin
      if (k != 4'b0) begin
        for (int yy = 0; yy < ROWS; yy++)
          for (int xx = 0; xx < COLS; xx++) grid[yy][xx] = 1'b0;
        mlines = 0; mover = 1'b0; mgrav = 0; mx = COLS / 2; my = 0;
      end
      return;
    end
    if (left && !right && mx > 0 && !grid[my][mx-1])             mx--;
    else if (right && !left && mx < COLS-1 && !grid[my][mx+1])   mx++;
    for (int step = 0; step <= ROWS; step++) begin
      if (!(down || up || mgrav == GRAV)) break;
      mgrav = 0; down = 1'b0;
      if (my == ROWS-1 || grid[my+1][mx]) begin locked = 1'b1; break; end
      my++;
      if (!up) break;
    end
    if (locked) begin
      grid[my][mx] = 1'b1;
      for (int yy = 0; yy < ROWS; yy++)
        for (int xx = 0; xx < COLS; xx++) ng[yy][xx] = 1'b0;
      dst = ROWS - 1; cleared = 0;
      for (int s = ROWS - 1; s >= 0; s--) begin
        full = 1'b1;
        for (int xx = 0; xx < COLS; xx++) if (!grid[s][xx]) full = 1'b0;
        if (full) cleared++;
        else begin
          for (int xx = 0; xx < COLS; xx++) ng[dst][xx] = grid[s][xx];
          dst--;
        end
      end
      grid = ng;
      mlines = (mlines + cleared > MAXL) ? MAXL : mlines + cleared;
      mx = COLS / 2; my = 0;
      if (grid[0][mx]) mover = 1'b1;
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; op_keys = '0; draw_finish = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // pre: keys pressed before the tick; acc: keys on the tick cycle;
  // bk: keys while busy; extra: a second tick that must be dropped.
  task automatic tick_frame(input logic [3:0] pre, input logic [3:0] acc,
                            input logic [3:0] bk, input bit extra);
    logic [N-1:0] prev;
    int cycles;
    @(negedge clk);
    op_keys = pre; m_latch = m_latch | pre;
    @(negedge clk);
    op_keys = acc; draw_finish = 1'b1; prev = data_updated;
    model_frame(m_latch);
    m_latch = acc;
    @(negedge clk);
    draw_finish = extra; op_keys = bk; m_latch = m_latch | bk;
    check("busy_after_tick", busy, 1'b1);
    check("no_update_on_tick", data_updated, prev);
    @(negedge clk);
    draw_finish = 1'b0; op_keys = '0; cycles = 2;
    while (busy && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    last_cycles = cycles;
    check("settle", busy, 1'b0);
    check("data", data_updated, model_view());
    check("game_over", game_over, mover);
    check("lines", lines_cleared, mlines);
  endtask

  logic [N-1:0] e;
  logic [3:0]   kp, ka, kb;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked while reset is held.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", data_updated, '0);
    check("rst_over", game_over, 1'b0);
    check("rst_lines", lines_cleared, '0);
    check("rst_busy", busy, 1'b0);
    model_reset();
    rst_n = 1'b1;

    // First tick with no keys: only the spawn cell, 4-cycle turnaround.
    tick_frame(4'b0, 4'b0, 4'b0, 1'b0);
    e = '0; e[COLS/2] = 1'b1;
    check("first_cell", data_updated, e);
    check("first_latency", last_cycles, 4);

    // Right four times saturates at the right wall, then left+right cancels.
    for (int i = 0; i < 4; i++) tick_frame(4'b1000, 4'b0, 4'b0, 1'b0);
    check("right_wall", data_updated[COLS-1 + COLS*my], 1'b1);
    tick_frame(4'b1100, 4'b0, 4'b0, 1'b0);

    // Gravity alone, then down on every frame.
    do_reset();
    for (int i = 0; i < 4; i++) tick_frame(4'b0, 4'b0, 4'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick_frame(4'b0010, 4'b0, 4'b0, 1'b0);

    // Fill bottom row columns 0..6, then drop into column 7 to clear it.
    do_reset();
    for (int c = 0; c < COLS; c++) begin
      for (int s = 0; s < (c < COLS/2 ? COLS/2 - c : c - COLS/2); s++)
        tick_frame(c < COLS/2 ? 4'b0100 : 4'b1000, 4'b0, 4'b0, 1'b0);
      tick_frame(4'b0001, 4'b0, 4'b0, 1'b0);
    end
    check("clear_lines", lines_cleared, 1);
    check("clear_bottom", data_updated[(ROWS-1)*COLS +: COLS], '0);

    // Hard drop on an empty field locks at the bottom and respawns.
    do_reset();
    tick_frame(4'b0001, 4'b0, 4'b0, 1'b0);
    check("hard_lock", data_updated[COLS/2 + COLS*(ROWS-1)], 1'b1);
    check("hard_respawn", data_updated[COLS/2], 1'b1);

    // Stack the centre column to the top for game over, then restart.
    for (int i = 0; i < ROWS + 2 && !mover; i++) tick_frame(4'b0001, 4'b0, 4'b0, 1'b0);
    check("stack_over", game_over, 1'b1);
    e = '0;
    for (int yy = 0; yy < ROWS; yy++) e[COLS/2 + COLS*yy] = 1'b1;
    check("over_view", data_updated, e);
    tick_frame(4'b0, 4'b0, 4'b0, 1'b0);
    tick_frame(4'b0010, 4'b0, 4'b0, 1'b0);
    e = '0; e[COLS/2] = 1'b1;
    check("restart_view", data_updated, e);
    check("restart_over", game_over, 1'b0);

    // Keys on the accept cycle and while busy count next frame; extra tick dropped.
    tick_frame(4'b0, 4'b1000, 4'b0, 1'b1);
    tick_frame(4'b0, 4'b0, 4'b0100, 1'b1);
    tick_frame(4'b0, 4'b0, 4'b0, 1'b0);

    // Reset in the middle of a hard drop leaves nothing behind.
    @(negedge clk); op_keys = 4'b0001;
    @(negedge clk); op_keys = 4'b0; draw_finish = 1'b1;
    @(negedge clk); draw_finish = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_data", data_updated, '0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    tick_frame(4'b0, 4'b0, 4'b0, 1'b0);

    // Randomized play.
    for (int i = 0; i < 300; i++) begin
      kp = 4'($urandom);
      if ($urandom_range(0, 3) != 0) kp[0] = 1'b0;
      ka = ($urandom_range(0, 5) == 0) ? (4'($urandom) & 4'b1110) : 4'b0;
      kb = ($urandom_range(0, 5) == 0) ? (4'($urandom) & 4'b1110) : 4'b0;
      tick_frame(kp, ka, kb, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
